// File: rtl/loader_pkg.sv
// ============================================================================
// Module      : loader_pkg
// Description : Shared types and constants for the byte-stream program loader.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package loader_pkg;

    localparam int LEN_W = 16;
    localparam logic [2:0] FUNCT3_WORD = 3'b010;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_LO = 3'd1,
        LEN_HI = 3'd2,
        DATA   = 3'd3,
        WRITE  = 3'd4,
        DONE   = 3'd5,
        ERROR  = 3'd6
    } state_t;

endpackage

`default_nettype wire

// File: rtl/loader_timeout.sv
// ============================================================================
// Module      : loader_timeout
// Description : Idle-gap counter; expired is high once LIMIT idle cycles elapse.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module loader_timeout #(
    parameter int unsigned LIMIT = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] count;

    assign expired = (count == CNT_W'(LIMIT));

    // Saturates at LIMIT so a late clear still sees a consistent value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/program_loader.sv
// ============================================================================
// Module      : program_loader
// Description : Receives a length-prefixed little-endian byte stream and writes
//               it as 32-bit words to memory while holding the CPU.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module program_loader
    import loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDRESS   = 32'h0000_0000,
    parameter int unsigned MAX_WORDS      = 2048,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        memory_write_en,
    output logic [31:0] memory_write_address,
    output logic [31:0] memory_write,
    output logic [2:0]  memory_funct3,
    output logic        cpu_hold,
    output logic        load_done,
    output logic        load_error
);

    state_t             state;
    state_t             state_nx;
    logic [7:0]         len_lo;
    logic [LEN_W-1:0]   len_full;
    logic [LEN_W-1:0]   word_count;
    logic [LEN_W-1:0]   word_idx;
    logic [1:0]         byte_idx;
    logic [23:0]        word_buf;
    logic               xfer;
    logic               start_ok;
    logic               expired;

    assign byte_ready    = (state == LEN_LO) || (state == LEN_HI) || (state == DATA);
    assign xfer          = byte_valid && byte_ready;
    assign start_ok      = load_start && ((state == IDLE) || (state == DONE) || (state == ERROR));
    assign len_full      = {byte_data, len_lo};

    assign memory_write_en = (state == WRITE);
    assign memory_funct3   = FUNCT3_WORD;
    assign cpu_hold        = (state != DONE);
    assign load_done       = (state == DONE);
    assign load_error      = (state == ERROR);

    loader_timeout #(
        .LIMIT   (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (xfer || start_ok),
        .enable  (byte_ready && !xfer),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // An accepted byte always takes priority over an expiring timeout.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE, ERROR: if (load_start) state_nx = LEN_LO;
            LEN_LO: begin
                if (xfer)         state_nx = LEN_HI;
                else if (expired) state_nx = ERROR;
            end
            LEN_HI: begin
                if (xfer) begin
                    if (len_full == '0)                state_nx = DONE;
                    else if (32'(len_full) > MAX_WORDS) state_nx = ERROR;
                    else                                state_nx = DATA;
                end else if (expired) begin
                    state_nx = ERROR;
                end
            end
            DATA: begin
                if (xfer && (byte_idx == 2'd3)) state_nx = WRITE;
                else if (!xfer && expired)      state_nx = ERROR;
            end
            WRITE: begin
                if ((word_idx + 1'b1) == word_count) state_nx = DONE;
                else                                 state_nx = DATA;
            end
            default: state_nx = IDLE;
        endcase
    end

    // The fourth byte goes straight into the output word, so only three are buffered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_lo               <= '0;
            word_count           <= '0;
            word_idx             <= '0;
            byte_idx             <= '0;
            word_buf             <= '0;
            memory_write_address <= '0;
            memory_write         <= '0;
        end else begin
            if (start_ok) begin
                word_idx <= '0;
                byte_idx <= '0;
            end
            if ((state == LEN_LO) && xfer) len_lo <= byte_data;
            if ((state == LEN_HI) && xfer) word_count <= len_full;
            if ((state == DATA) && xfer) begin
                byte_idx <= byte_idx + 1'b1;
                case (byte_idx)
                    2'd0: word_buf[7:0]   <= byte_data;
                    2'd1: word_buf[15:8]  <= byte_data;
                    2'd2: word_buf[23:16] <= byte_data;
                    default: begin
                        memory_write         <= {byte_data, word_buf};
                        memory_write_address <= BASE_ADDRESS + (32'(word_idx) << 2);
                    end
                endcase
            end
            if (state == WRITE) word_idx <= word_idx + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_program_loader.sv
// ============================================================================
// Module      : tb_program_loader
// Description : Directed self-checking bench for program_loader.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_program_loader;

    localparam logic [31:0] BASE = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_start = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        byte_ready;
    logic        memory_write_en;
    logic [31:0] memory_write_address;
    logic [31:0] memory_write;
    logic [2:0]  memory_funct3;
    logic        cpu_hold;
    logic        load_done;
    logic        load_error;

    int checks = 0;
    int errors = 0;

    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];

    program_loader #(
        .BASE_ADDRESS   (BASE),
        .MAX_WORDS      (2048),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .load_start           (load_start),
        .byte_valid           (byte_valid),
        .byte_data            (byte_data),
        .byte_ready           (byte_ready),
        .memory_write_en      (memory_write_en),
        .memory_write_address (memory_write_address),
        .memory_write         (memory_write),
        .memory_funct3        (memory_funct3),
        .cpu_hold             (cpu_hold),
        .load_done            (load_done),
        .load_error           (load_error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (memory_write_en) begin
            wr_addr.push_back(memory_write_address);
            wr_data.push_back(memory_write);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
    endtask

    // Returns at the negedge just after the byte was accepted.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        repeat (gap) @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = b;
        n = 0;
        while (!byte_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) chk("byte_accept_timeout", 32'(n), 32'd0);
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic wait_end();
        int n;
        n = 0;
        while (!load_done && !load_error && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("wait_end_timeout", 32'(n), 32'd0);
    endtask

    initial begin
        int wbase;
        int cyc;
        logic [7:0] stall_bytes[12];
        logic [7:0] tmp[12] = '{8'hA3, 8'hA2, 8'hA1, 8'hA0, 8'hB3, 8'hB2, 8'hB1, 8'hB0,
                                8'hC3, 8'hC2, 8'hC1, 8'hC0};
        stall_bytes = tmp;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_hold",  32'(cpu_hold), 32'd1);
        chk("rst_ready", 32'(byte_ready), 32'd0);
        chk("rst_we",    32'(memory_write_en), 32'd0);
        chk("rst_flags", 32'({load_done, load_error}), 32'd0);
        chk("rst_addr",  memory_write_address, 32'd0);
        chk("rst_data",  memory_write, 32'd0);
        chk("rst_f3",    32'(memory_funct3), 32'd2);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_we", 32'(memory_write_en), 32'd0);

        // Normal load
        pulse_start();
        chk("norm_ready", 32'(byte_ready), 32'd1);
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'hEF, 0);
        send_byte(8'hBE, 0);
        send_byte(8'hAD, 0);
        send_byte(8'hDE, 0);
        chk("norm_w0_we",    32'(memory_write_en), 32'd1);
        chk("norm_w0_ready", 32'(byte_ready), 32'd0);
        chk("norm_w0_addr",  memory_write_address, BASE);
        chk("norm_w0_data",  memory_write, 32'hDEADBEEF);
        @(negedge clk);
        chk("norm_w0_strobe_once", 32'(memory_write_en), 32'd0);
        send_byte(8'h78, 0);
        send_byte(8'h56, 0);
        send_byte(8'h34, 0);
        send_byte(8'h12, 0);
        wait_end();
        chk("norm_nwr",  32'(wr_addr.size()), 32'd2);
        chk("norm_a1",   wr_addr[1], BASE + 32'd4);
        chk("norm_d1",   wr_data[1], 32'h12345678);
        chk("norm_done", 32'(load_done), 32'd1);
        chk("norm_hold", 32'(cpu_hold), 32'd0);
        chk("norm_err",  32'(load_error), 32'd0);
        chk("norm_hold_data", memory_write, 32'h12345678);

        // Zero length, restarted from DONE
        pulse_start();
        chk("zero_rehold", 32'(cpu_hold), 32'd1);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        chk("zero_done", 32'(load_done), 32'd1);
        chk("zero_hold", 32'(cpu_hold), 32'd0);
        chk("zero_nwr",  32'(wr_addr.size()), 32'd2);

        // Oversize (2049 words)
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h08, 0);
        chk("over_err",  32'(load_error), 32'd1);
        chk("over_hold", 32'(cpu_hold), 32'd1);
        chk("over_done", 32'(load_done), 32'd0);
        repeat (3) @(negedge clk);
        chk("over_nwr",  32'(wr_addr.size()), 32'd2);

        // Timeout after three bytes of the first word
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'hEF, 0);
        send_byte(8'hBE, 0);
        send_byte(8'hAD, 0);
        cyc = 0;
        while (!load_error && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk("tmo_cycles", 32'(cyc), 32'd17);
        chk("tmo_err",    32'(load_error), 32'd1);
        chk("tmo_nwr",    32'(wr_addr.size()), 32'd2);

        // Reset mid-load after byte 2 of word 1
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'hEF, 0);
        send_byte(8'hBE, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_hold",  32'(cpu_hold), 32'd1);
        chk("mrst_ready", 32'(byte_ready), 32'd0);
        chk("mrst_flags", 32'({memory_write_en, load_done, load_error}), 32'd0);
        chk("mrst_addr",  memory_write_address, 32'd0);
        chk("mrst_data",  memory_write, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mrst_rel_we", 32'(memory_write_en), 32'd0);
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h33, 0);
        send_byte(8'h44, 0);
        wait_end();
        chk("mrst_nwr",  32'(wr_addr.size()), 32'd3);
        chk("mrst_addr2", wr_addr[2], BASE);
        chk("mrst_data2", wr_data[2], 32'h44332211);
        chk("mrst_done", 32'(load_done), 32'd1);

        // Stalls, ignored load_start in DATA, second load overwrites memory
        pulse_start();
        chk("stall_rehold", 32'(cpu_hold), 32'd1);
        send_byte(8'h03, 0);
        send_byte(8'h00, 0);
        wbase = wr_addr.size();
        for (int i = 0; i < 12; i++) begin
            send_byte(stall_bytes[i], int'($urandom_range(0, 10)));
            if (i == 5) begin
                pulse_start();
                chk("stall_start_ignored", 32'({byte_ready, load_done, load_error}), 32'b100);
            end
        end
        wait_end();
        chk("stall_nwr",  32'(wr_addr.size()), 32'(wbase + 3));
        chk("stall_a0",   wr_addr[wbase],     BASE);
        chk("stall_d0",   wr_data[wbase],     32'hA0A1A2A3);
        chk("stall_a1",   wr_addr[wbase + 1], BASE + 32'd4);
        chk("stall_d1",   wr_data[wbase + 1], 32'hB0B1B2B3);
        chk("stall_a2",   wr_addr[wbase + 2], BASE + 32'd8);
        chk("stall_d2",   wr_data[wbase + 2], 32'hC0C1C2C3);
        chk("stall_done", 32'({load_done, cpu_hold, load_error}), 32'b100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
